// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo_main write-port arbiter: FSM encodings and
// the data width constant shared with fifo_main.
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   localparam int FIFO_DATA_W = 64;
   localparam int DEF_DATA_W  = FIFO_DATA_W;

   // Width of a counter able to hold 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr,
// wrapping NUM_REQ-1 -> 0, as one-hot winner, index and an any flag.
module fifo_wr_arbiter_rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            win[cand] = 1'b1;
            win_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing fifo_main's write port between
// NUM_REQ producers. Optional per-requester beat counters: FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 4
`ifdef FIFO_ARB_STATS_EN
   ,
   parameter int CNT_W     = 16
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic [DATA_W-1:0]         fifo_din,
   output logic                      fifo_wr_en,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]  beat_cnt_o
`endif
);

   localparam int IDX_W  = idx_width(NUM_REQ);
   localparam int BCNT_W = idx_width(MAX_BURST);
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);

   arb_state_e         state;
   logic [BCNT_W-1:0]  beat_cnt;
   logic [IDX_W-1:0]   rr_ptr;

   logic [NUM_REQ-1:0] pick_win;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               granted_valid;
   logic [NUM_REQ-1:0] accepted;

   fifo_wr_arbiter_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Handshake outputs are combinational so a beat moves in the cycle it is offered.
   assign busy          = (state == ARB_BURST);
   assign req_ready     = grant & {NUM_REQ{busy & ~fifo_full}};
   assign accepted      = req_valid & req_ready;
   assign fifo_wr_en    = |accepted;
   assign granted_valid = |(req_valid & grant);

   always_comb begin
      fifo_din = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            fifo_din = fifo_din | req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ARB_IDLE;
         grant    <= '0;
         beat_cnt <= '0;
         rr_ptr   <= IDX_W'(NUM_REQ - 1);
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state    <= ARB_BURST;
                  grant    <= pick_win;
                  rr_ptr   <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            ARB_BURST: begin
               if (fifo_wr_en) begin
                  if (beat_cnt == LAST_BEAT) begin
                     state    <= ARB_IDLE;
                     grant    <= '0;
                     beat_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + BCNT_W'(1);
                  end
               end else if (!granted_valid) begin
                  // Owner withdrew (possibly before any beat): release the port.
                  state    <= ARB_IDLE;
                  grant    <= '0;
                  beat_cnt <= '0;
               end
               // Otherwise fifo_full is stalling the burst: hold everything.
            end
            default: begin
               state <= ARB_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [CNT_W-1:0] stat_cnt [NUM_REQ];

   // NOTE: this small counter array is reset explicitly because its contents
   // are visible on a port; a large storage array would normally not be.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i] && (stat_cnt[i] != '1)) begin
               stat_cnt[i] <= stat_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      beat_cnt_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         beat_cnt_o[i*CNT_W +: CNT_W] = stat_cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a queue standing in for fifo_main;
// checks grant/write timing and FIFO contents. FIFO_ARB_STATS_EN adds counter checks.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 2;
   localparam int DATA_W  = 64;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic [DATA_W-1:0]         fifo_din;
   logic                      fifo_wr_en;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;
`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]     beat_cnt_o;
`endif

   int total = 0;
   int bad   = 0;
   logic [63:0] fifo_q [$];
   int q_size_snap;

   int exp_g2 [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
   int exp_w2 [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
   int exp_g3 [15] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1};
   int exp_g4 [8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
   int exp_w4 [8]  = '{0, 1, 1, 0, 0, 1, 1, 0};

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .grant      (grant),
      .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .beat_cnt_o (beat_cnt_o)
`endif
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // fifo_main stand-in: a beat visible mid-cycle is the one taken at the next edge.
   always @(negedge clk) begin
      if (fifo_wr_en === 1'b1) begin
         check("no_write_while_full", {63'd0, fifo_full}, 64'd0);
         fifo_q.push_back(fifo_din);
      end
   end

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;

      // 1: reset held, then idle with no requests
      repeat (2) begin
         @(negedge clk);
         check("rst_grant", {62'd0, grant}, 64'd0);
         check("rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
         check("rst_busy", {63'd0, busy}, 64'd0);
      end
      next_cycle();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_grant", {62'd0, grant}, 64'd0);
         check("idle_wr_en", {63'd0, fifo_wr_en}, 64'd0);
         check("idle_busy", {63'd0, busy}, 64'd0);
         next_cycle();
      end

      // 2: single requester, six beats -> burst of 4, bubble, burst of 2
      req_data[63:0] = 64'h1;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 8) ? 2'b01 : 2'b00;
         @(negedge clk);
         check($sformatf("t2_grant_c%0d", c), {62'd0, grant}, 64'(exp_g2[c]));
         check($sformatf("t2_wr_en_c%0d", c), {63'd0, fifo_wr_en}, 64'(exp_w2[c]));
         if (c == 1) check("t2_din", fifo_din, 64'h1);
         if (c == 5) check("t2_bubble_busy", {63'd0, busy}, 64'd0);
         next_cycle();
      end
      check("t2_fifo_count", 64'(fifo_q.size()), 64'd6);
      for (int k = 0; k < fifo_q.size(); k++) check($sformatf("t2_fifo_%0d", k), fifo_q[k], 64'h1);

      // 3: both requesting continuously -> req0, req1, req0 bursts
      do_reset();
      fifo_q.delete();
      req_data  = {64'hB, 64'hA};
      req_valid = 2'b11;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         check($sformatf("t3_grant_c%0d", c), {62'd0, grant}, 64'(exp_g3[c]));
         next_cycle();
      end
      req_valid = 2'b00;
      @(negedge clk);
      check("t3_end_grant", {62'd0, grant}, 64'd0);
      check("t3_fifo_count", 64'(fifo_q.size()), 64'd12);
      for (int k = 0; k < fifo_q.size(); k++)
         check($sformatf("t3_fifo_%0d", k), fifo_q[k], (k >= 4 && k < 8) ? 64'hB : 64'hA);
`ifdef FIFO_ARB_STATS_EN
      check("t3_stats_req0", 64'(beat_cnt_o[15:0]), 64'd8);
      check("t3_stats_req1", 64'(beat_cnt_o[31:16]), 64'd4);
`endif
      next_cycle();

      // 4: fifo_full stalls the burst after beat 2, then beats 3 and 4 complete it
      fifo_q.delete();
      req_data[63:0] = 64'hC;
      for (int c = 0; c < 8; c++) begin
         req_valid = (c < 7) ? 2'b01 : 2'b00;
         fifo_full = (c == 3 || c == 4);
         @(negedge clk);
         check($sformatf("t4_grant_c%0d", c), {62'd0, grant}, 64'(exp_g4[c]));
         check($sformatf("t4_wr_en_c%0d", c), {63'd0, fifo_wr_en}, 64'(exp_w4[c]));
         if (c == 3) begin
            check("t4_stall_ready", {62'd0, req_ready}, 64'd0);
            check("t4_stall_busy", {63'd0, busy}, 64'd1);
         end
         next_cycle();
      end
      fifo_full = 1'b0;
      check("t4_fifo_count", 64'(fifo_q.size()), 64'd4);
      for (int k = 0; k < fifo_q.size(); k++) check($sformatf("t4_fifo_%0d", k), fifo_q[k], 64'hC);

      // 5: reset mid-burst clears outputs at once; req0 wins first afterwards
      fifo_q.delete();
      req_data  = {64'hD, 64'hE};
      req_valid = 2'b10;
      @(negedge clk);
      check("t5_idle_grant", {62'd0, grant}, 64'd0);
      next_cycle();
      @(negedge clk);
      check("t5_burst_grant", {62'd0, grant}, 64'd2);
      check("t5_burst_din", fifo_din, 64'hD);
      next_cycle();
      rst = 1'b0;
      #1;
      check("t5_rst_grant", {62'd0, grant}, 64'd0);
      check("t5_rst_wr_en", {63'd0, fifo_wr_en}, 64'd0);
      check("t5_rst_ready", {62'd0, req_ready}, 64'd0);
      check("t5_rst_busy", {63'd0, busy}, 64'd0);
      check("t5_rst_din", fifo_din, 64'd0);
      q_size_snap = fifo_q.size();
      check("t5_written_before_rst", 64'(q_size_snap), 64'd1);
      next_cycle();
      rst       = 1'b1;
      req_valid = 2'b11;
      check("t5_no_write_in_rst", 64'(fifo_q.size()), 64'd1);
      @(negedge clk);
      check("t5_after_idle", {62'd0, grant}, 64'd0);
      next_cycle();
      @(negedge clk);
      check("t5_req0_first", {62'd0, grant}, 64'd1);
      check("t5_req0_din", fifo_din, 64'hE);
      next_cycle();
      req_valid = 2'b00;
      repeat (2) next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
